// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM state type, BCD limits and BCD helper functions for the RTC core.
package rtc_pkg;

    typedef enum logic {RUN, APPLY} state_t;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
    endfunction

    // 20 and 21 borrow across the tens digit, so they need a different BCD offset
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        return h == 8'h00 ? 8'h12 :
               h <= 8'h12 ? h :
               (h == 8'h20 || h == 8'h21) ? h - 8'h18 : h - 8'h12;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: control, set/alarm handshake and time-display bus of the RTC core.
interface rtc_timekeeper_if;

    logic       en;
    logic       mode_12h;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_err;
    logic       alarm_en;
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       alarm_hit;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       pm;
    logic       tick;
    logic       day_wrap;

    modport master (
        output en, mode_12h, set_valid, set_hh, set_mm, set_ss, alarm_en, alarm_hh, alarm_mm,
        input  set_ready, set_err, alarm_hit, hh_bcd, mm_bcd, ss_bcd, pm, tick, day_wrap
    );

    modport slave (
        input  en, mode_12h, set_valid, set_hh, set_mm, set_ss, alarm_en, alarm_hh, alarm_mm,
        output set_ready, set_err, alarm_hit, hh_bcd, mm_bcd, ss_bcd, pm, tick, day_wrap
    );

endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides the input clock to the time-base; tc is the combinational terminal
// count, tick its registered pulse. clr restarts the count and swallows a coinciding tick.
module rtc_prescaler #(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int TICK_HZ     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc,
    output logic tick
);

    localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRESC_W = DIV > 1 ? $clog2(DIV) : 1;

    logic [PRESC_W-1:0] cnt;

    assign tc = en && cnt == PRESC_W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= clr || tc ? '0 : en ? cnt + 1'b1 : cnt;
            tick <= tc && !clr;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD hh:mm:ss real-time clock with set handshake, 12/24 h display and alarm.
// Time is kept in 24 h BCD; the 12 h view is derived on the output side only.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int TICK_HZ     = 1
) (
    input  logic clk_16mhz,
    input  logic rst_n,
    rtc_timekeeper_if.slave bus
);

    state_t     state;
    logic [7:0] hh, mm, ss, nhh, nmm, nss;
    logic       mode_q, accept, set_ok, tc, adv;

    assign accept = bus.set_valid && state == RUN;
    assign set_ok = bcd_valid(bus.set_hh, BCD_23) && bcd_valid(bus.set_mm, BCD_59) &&
                    bcd_valid(bus.set_ss, BCD_59);
    // an accepted set always beats a coinciding terminal count
    assign adv    = tc && !accept;
    assign nss    = bcd_inc(ss, BCD_59);
    assign nmm    = ss == BCD_59 ? bcd_inc(mm, BCD_59) : mm;
    assign nhh    = ss == BCD_59 && mm == BCD_59 ? bcd_inc(hh, BCD_23) : hh;

    rtc_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ)) u_presc (
        .clk   (clk_16mhz),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (accept),
        .tc    (tc),
        .tick  (bus.tick)
    );

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            hh            <= 8'h00;
            mm            <= 8'h00;
            ss            <= 8'h00;
            mode_q        <= 1'b0;
            bus.set_err   <= 1'b0;
            bus.day_wrap  <= 1'b0;
            bus.alarm_hit <= 1'b0;
        end else begin
            state         <= accept ? APPLY : RUN;
            mode_q        <= bus.mode_12h;
            bus.set_err   <= accept && !set_ok;
            bus.day_wrap  <= adv && {hh, mm, ss} == {BCD_23, BCD_59, BCD_59};
            bus.alarm_hit <= adv && bus.alarm_en && {nhh, nmm, nss} == {bus.alarm_hh, bus.alarm_mm, 8'h00};
            if (accept && set_ok) begin
                hh <= bus.set_hh;
                mm <= bus.set_mm;
                ss <= bus.set_ss;
            end else if (adv) begin
                hh <= nhh;
                mm <= nmm;
                ss <= nss;
            end
        end
    end

    assign bus.set_ready = state == RUN;
    assign bus.hh_bcd    = mode_q ? to_12h(hh) : hh;
    assign bus.mm_bcd    = mm;
    assign bus.ss_bcd    = ss;
    assign bus.pm        = hh >= 8'h12;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed stimulus; a seconds-of-day model is compared against the DUT
// every falling edge, with literal checks at the points of interest.
module tb_rtc_timekeeper;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rtc_timekeeper_if bus ();

    rtc_timekeeper #(.CLK_FREQ_HZ(16), .TICK_HZ(1)) dut (
        .clk_16mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [7:0] v, input int max);
        int n;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        return n > max ? -1 : n;
    endfunction

    function automatic logic [7:0] bcd(input int n);
        return 8'((n / 10) * 16 + n % 10);
    endfunction

    int m_cnt, m_secs, m_nxt, m_sh, m_sm, m_ss, m_ah, m_am;
    bit m_apply, m_err, m_tick, m_wrap, m_hit, m_mode, m_acc, m_tc, m_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_secs = 0; m_apply = 0; m_err = 0;
            m_tick = 0; m_wrap = 0; m_hit = 0; m_mode = 0;
        end else begin
            m_acc  = bus.set_valid && !m_apply;
            m_tc   = bus.en && m_cnt == DIV - 1;
            m_sh   = dec(bus.set_hh, 23);
            m_sm   = dec(bus.set_mm, 59);
            m_ss   = dec(bus.set_ss, 59);
            m_ok   = m_sh >= 0 && m_sm >= 0 && m_ss >= 0;
            m_ah   = dec(bus.alarm_hh, 23);
            m_am   = dec(bus.alarm_mm, 59);
            m_nxt  = (m_secs + 1) % 86400;
            m_tick = m_tc && !m_acc;
            m_err  = m_acc && !m_ok;
            m_wrap = m_tick && m_secs == 86399;
            m_hit  = m_tick && bus.alarm_en && m_ah >= 0 && m_am >= 0 && m_nxt == m_ah * 3600 + m_am * 60;
            m_cnt  = m_acc ? 0 : !bus.en ? m_cnt : m_tc ? 0 : m_cnt + 1;
            if (m_acc && m_ok) m_secs = m_sh * 3600 + m_sm * 60 + m_ss;
            else if (m_tick)   m_secs = m_nxt;
            m_apply = m_acc;
            m_mode  = bus.mode_12h;
        end
    end

    int c_h;
    always @(negedge clk) begin
        c_h = m_secs / 3600;
        chk("hh_bcd", bus.hh_bcd, bcd(m_mode ? (c_h % 12 == 0 ? 12 : c_h % 12) : c_h));
        chk("mm_bcd", bus.mm_bcd, bcd((m_secs / 60) % 60));
        chk("ss_bcd", bus.ss_bcd, bcd(m_secs % 60));
        chk("pm", bus.pm, c_h >= 12);
        chk("tick", bus.tick, m_tick);
        chk("set_err", bus.set_err, m_err);
        chk("day_wrap", bus.day_wrap, m_wrap);
        chk("alarm_hit", bus.alarm_hit, m_hit);
        chk("set_ready", bus.set_ready, !m_apply);
    end

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(posedge clk); #1;
        bus.set_valid = 1'b1; bus.set_hh = h; bus.set_mm = m; bus.set_ss = s;
        @(posedge clk); #1;
        bus.set_valid = 1'b0;
    endtask

    int cnt;

    initial begin
        bus.en = 0; bus.mode_12h = 0; bus.set_valid = 0;
        bus.set_hh = 0; bus.set_mm = 0; bus.set_ss = 0;
        bus.alarm_en = 0; bus.alarm_hh = 0; bus.alarm_mm = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst hh", bus.hh_bcd, 8'h00);
        chk("rst set_ready", bus.set_ready, 1'b1);
        chk("rst tick", bus.tick, 1'b0);
        rst_n = 1'b1; bus.en = 1'b1;
        // one tick after 16 enabled cycles
        cnt = 0;
        repeat (16) begin @(posedge clk); #1; cnt += int'(bus.tick); end
        chk("t1 tick count", cnt, 1);
        chk("t1 ss", bus.ss_bcd, 8'h01);
        // midnight rollover
        do_set(8'h23, 8'h59, 8'h58);
        chk("t2 set hh", bus.hh_bcd, 8'h23);
        cnt = 0;
        repeat (32) begin @(posedge clk); #1; cnt += int'(bus.day_wrap); end
        chk("t2 wrap count", cnt, 1);
        chk("t2 time", {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 24'h000000);
        // invalid sets
        do_set(8'h24, 8'h00, 8'h00);
        chk("t3 err hh", bus.set_err, 1'b1);
        chk("t3 time hh", {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 24'h000000);
        do_set(8'h10, 8'h00, 8'h5A);
        chk("t3 err ss", bus.set_err, 1'b1);
        chk("t3 time ss", {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 24'h000000);
        // 12 h display
        @(posedge clk); #1;
        bus.mode_12h = 1'b1;
        chk("t4 mode delay", bus.hh_bcd, 8'h00);
        @(posedge clk); #1;
        chk("t4 hh 00", bus.hh_bcd, 8'h12);
        chk("t4 pm 00", bus.pm, 1'b0);
        do_set(8'h13, 8'h05, 8'h00);
        chk("t4 hh 13", bus.hh_bcd, 8'h01);
        chk("t4 pm 13", bus.pm, 1'b1);
        do_set(8'h21, 8'h00, 8'h00);
        chk("t4 hh 21", bus.hh_bcd, 8'h09);
        bus.mode_12h = 1'b0;
        // alarm
        bus.alarm_en = 1'b1; bus.alarm_hh = 8'h07; bus.alarm_mm = 8'h30;
        do_set(8'h07, 8'h29, 8'h59);
        cnt = 0;
        repeat (16) begin @(posedge clk); #1; cnt += int'(bus.alarm_hit); end
        chk("t5 hit count", cnt, 1);
        chk("t5 mm", bus.mm_bcd, 8'h30);
        do_set(8'h07, 8'h30, 8'h00);
        cnt = int'(bus.alarm_hit);
        repeat (10) begin @(posedge clk); #1; cnt += int'(bus.alarm_hit); end
        chk("t5 no hit on set", cnt, 0);
        // frozen while disabled, set still applies
        bus.en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("en0 frozen", bus.ss_bcd, 8'h00);
        do_set(8'h10, 8'h00, 8'h00);
        chk("en0 set", bus.hh_bcd, 8'h10);
        bus.en = 1'b1;
        // set on the terminal-count cycle
        do_set(8'h01, 8'h02, 8'h03);
        repeat (15) @(posedge clk);
        #1;
        bus.set_valid = 1'b1; bus.set_hh = 8'h12; bus.set_mm = 8'h34; bus.set_ss = 8'h56;
        @(posedge clk); #1;
        bus.set_valid = 1'b0;
        chk("t6 no tick", bus.tick, 1'b0);
        chk("t6 time", {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 24'h123456);
        // reset mid-count with a set in flight
        repeat (5) @(posedge clk);
        #1;
        bus.set_valid = 1'b1; bus.set_hh = 8'h05; bus.set_mm = 8'h00; bus.set_ss = 8'h00;
        @(posedge clk); #1;
        bus.set_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6 rst time", {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 24'h000000);
        chk("t6 rst pm", bus.pm, 1'b0);
        chk("t6 rst ready", bus.set_ready, 1'b1);
        chk("t6 rst tick", bus.tick, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
